// File: rtl/mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_if
// Bundles the execute-stage request, MTHI/MTLO write port, hazard-unit stall
// and the HI/LO result view of the multiply/divide unit.
//
//   start   request from execute (MULT/MULTU/DIV/DIVU)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srca    rs operand (dividend / multiplicand)
//   srcb    rt operand (divisor / multiplier)
//   cancel  pipeline flush, aborts a running operation
//   hi_we   MTHI write enable
//   lo_we   MTLO write enable
//   wdata   MTHI/MTLO data
//   stall_o stall request to the hazard unit
//   busy    unit is not idle
//   done    one-cycle pulse, HI/LO hold the new result
//   hi, lo  architectural HI/LO registers
//
// master: the pipeline side, slave: mdu_ctrl.
// -----------------------------------------------------------------------------
interface mdu_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             cancel;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             stall_o;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srca, srcb, cancel, hi_we, lo_we, wdata,
      input  stall_o, busy, done, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb, cancel, hi_we, lo_we, wdata,
      output stall_o, busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide controller for the 5-stage MIPS pipeline. Runs a single-cycle
// MULT/MULTU or a 32-iteration radix-2 restoring DIV/DIVU, stalls stages F-E
// through the hazard unit while working, and owns the HI/LO registers that
// MTHI/MTLO write and MFHI/MFLO read.
//
// Ports:
//   clk   pipeline clock, rising edge
//   rst   asynchronous active-low reset
//   bus   mdu_ctrl_if.slave (request, MTHI/MTLO, stall_o, busy, done, hi, lo)
//
// Optional feature: define MDU_EARLY_OUT_EN to finish a divide in one cycle
// when |divisor| > |dividend| (quotient 0, remainder = dividend). Results are
// identical with or without it; only latency differs.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   mdu_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               done_r;
   logic               busy_r;

   // operand / divider datapath (no reset needed, always loaded before use)
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic               mul_signed_r;
   logic [WIDTH-1:0]   dvd_r;     // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0]   dvs_r;     // divisor magnitude
   logic [WIDTH-1:0]   rem_r;     // partial remainder magnitude
   logic               neg_q_r;
   logic               neg_r_r;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
   // which is still correct when read as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                            input logic                    is_signed);
      return (is_signed && (v < 0)) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
      return neg ? -v : v;
   endfunction

   // op[0]=0 selects the signed flavour for both MULT and DIV
   logic               req_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   always_comb begin
      req_signed = ~bus.op[0];
      a_mag      = mag(bus.srca, req_signed);
      b_mag      = mag(bus.srcb, req_signed);
   end

   // ---- multiply: full-width product from the latched operands ----
   logic [2*WIDTH-1:0]        ext_a;
   logic [2*WIDTH-1:0]        ext_b;
   logic signed [2*WIDTH-1:0] prod;

   always_comb begin
      ext_a = mul_signed_r ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
      ext_b = mul_signed_r ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
      prod  = $signed(ext_a * ext_b);
   end

   // ---- divide: one restoring step per cycle ----
   // rem_r < dvs_r, so the shifted remainder minus the divisor always fits in
   // WIDTH+1 bits and its top bit is a valid sign.
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic               take;
   logic [WIDTH-1:0]   rem_nx;
   logic [WIDTH-1:0]   quo_nx;

   always_comb begin
      rem_sh = {rem_r, dvd_r[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_r};
      take   = ~diff[WIDTH];
      rem_nx = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_nx = {dvd_r[WIDTH-2:0], take};
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.start) begin
         a_r          <= bus.srca;
         b_r          <= bus.srcb;
         mul_signed_r <= req_signed;
         dvd_r        <= a_mag;
         dvs_r        <= b_mag;
         rem_r        <= '0;
         neg_q_r      <= req_signed & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
         neg_r_r      <= req_signed & bus.srca[WIDTH-1];
      end else if (state == S_DIV) begin
         dvd_r        <= quo_nx;
         rem_r        <= rem_nx;
      end
   end

   // ---- control FSM and HI/LO ----
   // MTHI/MTLO are applied first so a result write on the same edge overrides.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.hi_we) hi_r <= bus.wdata;
               if (bus.lo_we) lo_r <= bus.wdata;
               if (bus.start) begin
                  busy_r <= 1'b1;
                  if (!bus.op[1]) begin
                     state <= S_MUL;
                  end else if (bus.srcb == '0) begin
                     lo_r   <= '1;
                     hi_r   <= bus.srca;
                     done_r <= 1'b1;
                     state  <= S_DONE;
`ifdef MDU_EARLY_OUT_EN
                  end else if (b_mag > a_mag) begin
                     lo_r   <= '0;
                     hi_r   <= bus.srca;
                     done_r <= 1'b1;
                     state  <= S_DONE;
`endif
                  end else begin
                     cnt   <= '0;
                     state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (bus.cancel) begin
                  busy_r <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  {hi_r, lo_r} <= prod;
                  done_r       <= 1'b1;
                  state        <= S_DONE;
               end
            end
            S_DIV: begin
               if (bus.cancel) begin
                  busy_r <= 1'b0;
                  state  <= S_IDLE;
               end else if (cnt == CNT_W'(WIDTH-1)) begin
                  lo_r   <= cond_neg(quo_nx, neg_q_r);
                  hi_r   <= cond_neg(rem_nx, neg_r_r);
                  done_r <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (bus.hi_we) hi_r <= bus.wdata;
               if (bus.lo_we) lo_r <= bus.wdata;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stall is combinational so a cancel releases the pipeline in the same cycle.
   always_comb begin
      bus.stall_o = rst & ~bus.cancel &
                    ((state == S_IDLE && bus.start) || state == S_MUL || state == S_DIV);
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
// Directed and randomized checks of mdu_ctrl against a behavioural model that
// computes HI/LO with 64-bit integer arithmetic and latency from the op class.
// Define MDU_EARLY_OUT_EN for both DUT and bench to check the early-out build.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_ctrl_if #(.WIDTH(32)) bus ();

   mdu_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: integer division truncates toward zero and the remainder takes
   // the dividend's sign; 64-bit arithmetic avoids the -2^31/-1 overflow.
   task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
      longint sa, sb, q, r, p;
      sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
      sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
      if (!o[1]) begin
         p   = sa * sb;
         rhi = p[63:32];
         rlo = p[31:0];
         lat = 2;
      end else if (b == 32'd0) begin
         rhi = a;
         rlo = 32'hFFFF_FFFF;
         lat = 1;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         rhi = r[31:0];
         rlo = q[31:0];
         lat = 33;
`ifdef MDU_EARLY_OUT_EN
         if ((sb < 0 ? -sb : sb) > (sa < 0 ? -sa : sa)) lat = 1;
`endif
      end
   endtask

   // One request: start in cycle 0, optional cancel / lo_we pulse in a given
   // cycle, optional MTHI+MTLO colliding with the request in cycle 0.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_cyc, input int lowe_cyc, input bit mt0,
                         input string tag);
      logic [31:0] ehi, elo;
      int          elat;
      int          stall_cnt;
      int          done_cyc;
      ref_model(o, a, b, ehi, elo, elat);
      stall_cnt = 0;
      done_cyc  = -1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = o; bus.srca = a; bus.srcb = b;
      if (mt0) begin
         bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_0F0F;
      end
      for (int c = 0; c <= 40 && done_cyc < 0; c++) begin
         if (c == cancel_cyc) bus.cancel = 1'b1;
         if (c == lowe_cyc) begin
            bus.lo_we = 1'b1; bus.wdata = $urandom;
         end
         @(negedge clk);
         if (c == 0) chk({tag, "/hi_before"}, 64'(bus.hi), 64'(m_hi));
         if (bus.stall_o) stall_cnt++;
         if (c == cancel_cyc) chk({tag, "/stall_on_cancel"}, 64'(bus.stall_o), 64'd0);
         if (cancel_cyc >= 0 && c == cancel_cyc + 1)
            chk({tag, "/busy_after_cancel"}, 64'(bus.busy), 64'd0);
         if (bus.done) begin
            done_cyc = c;
            chk({tag, "/hi_in_done"}, 64'(bus.hi), 64'(ehi));
            chk({tag, "/lo_in_done"}, 64'(bus.lo), 64'(elo));
         end
         @(posedge clk); #1;
         bus.start = 1'b0; bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
         bus.op = 2'($urandom); bus.srca = $urandom; bus.srcb = $urandom;
      end
      if (cancel_cyc >= 0) begin
         chk({tag, "/no_done"}, 64'(done_cyc), 64'(-1));
         chk({tag, "/stall_cycles"}, 64'(stall_cnt), 64'(cancel_cyc));
         chk({tag, "/hi_kept"}, 64'(bus.hi), 64'(m_hi));
         chk({tag, "/lo_kept"}, 64'(bus.lo), 64'(m_lo));
      end else begin
         chk({tag, "/done_cycle"}, 64'(done_cyc), 64'(elat));
         chk({tag, "/stall_cycles"}, 64'(stall_cnt), 64'(elat));
         chk({tag, "/busy_after"}, 64'(bus.busy), 64'd0);
         m_hi = ehi;
         m_lo = elo;
      end
   endtask

   task automatic do_mt(input bit wh, input bit wl, input logic [31:0] d);
      @(posedge clk); #1;
      bus.hi_we = wh; bus.lo_we = wl; bus.wdata = d;
      @(posedge clk); #1;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      if (wh) m_hi = d;
      if (wl) m_lo = d;
      chk("mt/hi", 64'(bus.hi), 64'(m_hi));
      chk("mt/lo", 64'(bus.lo), 64'(m_lo));
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      n_assert = 0;
      n_fail   = 0;
      m_hi     = '0;
      m_lo     = '0;
      rst = 1'b0;
      bus.start = 1'b1; bus.op = 2'b11; bus.srca = 32'd50; bus.srcb = 32'd3;
      bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

      // reset state, stall forced low even with start asserted
      repeat (3) @(posedge clk);
      #1;
      chk("rst/stall_o", 64'(bus.stall_o), 64'd0);
      chk("rst/busy", 64'(bus.busy), 64'd0);
      chk("rst/done", 64'(bus.done), 64'd0);
      chk("rst/hi", 64'(bus.hi), 64'd0);
      chk("rst/lo", 64'(bus.lo), 64'd0);
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      // multiply, unsigned then signed
      run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, -1, -1, 1'b0, "multu");
      chk("multu/hi_const", 64'(bus.hi), 64'h0000_0001);
      chk("multu/lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
      run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, -1, -1, 1'b0, "mult");
      chk("mult/hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
      chk("mult/lo_const", 64'(bus.lo), 64'hFFFF_FFFE);

      // divides
      run_op(2'b11, 32'd100, 32'd7, -1, -1, 1'b0, "divu_100_7");
      chk("divu_100_7/lo_const", 64'(bus.lo), 64'h0000_000E);
      chk("divu_100_7/hi_const", 64'(bus.hi), 64'h0000_0002);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0, "div_m7_2");
      chk("div_m7_2/lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
      chk("div_m7_2/hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0, "div_ovf");
      chk("div_ovf/lo_const", 64'(bus.lo), 64'h8000_0000);
      chk("div_ovf/hi_const", 64'(bus.hi), 64'h0000_0000);

      // divide by zero, with a colliding MTHI/MTLO that must lose
      run_op(2'b10, 32'h1234_5678, 32'd0, -1, -1, 1'b1, "div0");
      chk("div0/lo_const", 64'(bus.lo), 64'hFFFF_FFFF);
      chk("div0/hi_const", 64'(bus.hi), 64'h1234_5678);

      // cancel mid-divide
      run_op(2'b11, 32'd1000, 32'd3, 10, -1, 1'b0, "cancel");

      // MTHI, then a divide with lo_we pulsed while dividing
      do_mt(1'b1, 1'b0, 32'hA5A5_A5A5);
      run_op(2'b11, 32'd5, 32'd9, -1, 5, 1'b0, "divu_5_9");
      chk("divu_5_9/lo_const", 64'(bus.lo), 64'h0000_0000);
      chk("divu_5_9/hi_const", 64'(bus.hi), 64'h0000_0005);
      do_mt(1'b1, 1'b1, 32'h0BAD_F00D);

      // randomized operations
      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, -1, -1, 1'b0, "rnd");
      end

      // reset asserted in cycle 15 of a divide
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b11; bus.srca = 32'hDEAD_BEEF; bus.srcb = 32'd13;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("rstmid/busy_before", 64'(bus.busy), 64'd1);
      rst = 1'b0;
      #2;
      m_hi = '0;
      m_lo = '0;
      chk("rstmid/hi", 64'(bus.hi), 64'(m_hi));
      chk("rstmid/lo", 64'(bus.lo), 64'(m_lo));
      chk("rstmid/busy", 64'(bus.busy), 64'd0);
      chk("rstmid/stall_o", 64'(bus.stall_o), 64'd0);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rstmid/idle_done", 64'(bus.done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
